// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request in flight, and buffers the returned word for the IF/ID register.
// An empty buffer is presented as NOP_INSTR, so the register downstream needs
// no valid bit of its own.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallf,
    input  logic        pc_redirect,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrf,
    output logic [31:0] pcf,
    output logic [31:0] pc4f,
    output logic        validf
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] pc_plus4;
    logic            kill;
    logic            kill_n;
    logic            validf_n;
    logic [XLEN-1:0] instrf_n;
    logic [XLEN-1:0] pcf_n;
    logic [XLEN-1:0] pc4f_n;

    // Sequential PC arithmetic wraps naturally at 2^32.
    assign pc_plus4  = pc + INSTR_BYTES;
    assign imem_addr = pc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_n;
        end
    end

    // PC, kill flag and the IF/ID-facing buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            kill   <= 1'b0;
            validf <= 1'b0;
            instrf <= NOP_INSTR;
            pcf    <= RESET_PC;
            pc4f   <= RESET_PC + INSTR_BYTES;
        end else begin
            pc     <= pc_n;
            kill   <= kill_n;
            validf <= validf_n;
            instrf <= instrf_n;
            pcf    <= pcf_n;
            pc4f   <= pc4f_n;
        end
    end

    // Next-state decode; redirect outranks a response, which outranks a stall.
    always_comb begin
        state_n = state;
        case (state)
            S_REQ: begin
                if (!pc_redirect) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pc_redirect) begin
                    // Response arriving with the redirect is dropped outright;
                    // otherwise keep waiting and discard it later via kill.
                    state_n = imem_rvalid ? S_REQ : S_WAIT;
                end else if (imem_rvalid) begin
                    state_n = kill ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (pc_redirect) begin
                    state_n = S_REQ;
                end else if (!stallf) begin
                    state_n = S_WAIT;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

    // Next values for the PC, kill flag and fetch buffer.
    always_comb begin
        pc_n     = pc;
        kill_n   = kill;
        validf_n = validf;
        instrf_n = instrf;
        pcf_n    = pcf;
        pc4f_n   = pc4f;
        case (state)
            S_REQ: begin
                if (pc_redirect) begin
                    pc_n = pc_target;
                end
            end
            S_WAIT: begin
                if (pc_redirect) begin
                    pc_n   = pc_target;
                    kill_n = !imem_rvalid;
                end else if (imem_rvalid) begin
                    if (kill) begin
                        kill_n = 1'b0;
                    end else begin
                        instrf_n = imem_rdata;
                        pcf_n    = pc;
                        pc4f_n   = pc_plus4;
                        validf_n = 1'b1;
                        pc_n     = pc_plus4;
                    end
                end
            end
            S_HOLD: begin
                if (pc_redirect) begin
                    validf_n = 1'b0;
                    instrf_n = NOP_INSTR;
                    pc_n     = pc_target;
                end else if (!stallf) begin
                    // IF/ID takes the buffer on this edge; pcf/pc4f keep their values.
                    validf_n = 1'b0;
                    instrf_n = NOP_INSTR;
                end
            end
            default: begin
                pc_n = pc;
            end
        endcase
    end

    // Request strobe decoded from state and inputs; quiet while in reset.
    always_comb begin
        imem_req = 1'b0;
        case (state)
            S_REQ:   imem_req = !pc_redirect;
            S_WAIT:  imem_req = 1'b0;
            S_HOLD:  imem_req = !pc_redirect && !stallf;
            default: imem_req = 1'b0;
        endcase
        if (!rst_n) begin
            imem_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a variable-latency instruction memory model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stallf;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrf;
    logic [31:0] pcf;
    logic [31:0] pc4f;
    logic        validf;

    int ncmp  = 0;
    int nfail = 0;
    int lat   = 1;

    logic        busy;
    logic [31:0] addr_q;
    int          cnt;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stallf     (stallf),
        .pc_redirect(pc_redirect),
        .pc_target  (pc_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instrf     (instrf),
        .pcf        (pcf),
        .pc4f       (pc4f),
        .validf     (validf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: answers each request 'lat' cycles later with a one-cycle rvalid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            cnt         <= 0;
            addr_q      <= 32'h0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_req) begin
                addr_q <= imem_addr;
                if (lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(imem_addr);
                    busy        <= 1'b0;
                end else begin
                    busy <= 1'b1;
                    cnt  <= lat - 1;
                end
            end else if (busy) begin
                if (cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(addr_q);
                    busy        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b1;
        stallf      = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = 32'h0;
        #1 rst_n = 1'b0;
        #2;
        // Reset state
        chk("rst_validf", 32'(validf), 32'd0);
        chk("rst_instrf", instrf, NOP);
        chk("rst_pcf", pcf, 32'h0);
        chk("rst_pc4f", pc4f, 32'h4);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);

        // T1: first fetch after reset release, 1-cycle memory
        cyc();
        rst_n = 1'b1;
        #1;
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        cyc();
        chk("t1_wait_req", 32'(imem_req), 32'd0);
        chk("t1_wait_valid", 32'(validf), 32'd0);
        cyc();
        chk("t1_valid", 32'(validf), 32'd1);
        chk("t1_instr", instrf, 32'h0050_0093);
        chk("t1_pcf", pcf, 32'h0);
        chk("t1_pc4f", pc4f, 32'h4);
        chk("t1_next_addr", imem_addr, 32'h4);

        // T2: stall three cycles in S_HOLD
        stallf = 1'b1;
        #1;
        chk("t2_req_stall", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("t2_valid_hold", 32'(validf), 32'd1);
            chk("t2_instr_hold", instrf, 32'h0050_0093);
            chk("t2_pcf_hold", pcf, 32'h0);
            chk("t2_req_hold", 32'(imem_req), 32'd0);
        end
        stallf = 1'b0;
        #1;
        chk("t2_req_release", 32'(imem_req), 32'd1);
        chk("t2_addr_release", imem_addr, 32'h4);
        cyc();
        chk("t2_valid_drop", 32'(validf), 32'd0);
        chk("t2_instr_nop", instrf, NOP);
        chk("t2_pcf_kept", pcf, 32'h0);
        chk("t2_pc4f_kept", pc4f, 32'h4);
        cyc();
        chk("t2_valid2", 32'(validf), 32'd1);
        chk("t2_instr2", instrf, mem_word(32'h4));
        chk("t2_pcf2", pcf, 32'h4);
        chk("t2_pc4f2", pc4f, 32'h8);

        // T5: redirect while stalled in S_HOLD
        stallf      = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = 32'h40;
        #1;
        chk("t5_req", 32'(imem_req), 32'd0);
        cyc();
        pc_redirect = 1'b0;
        stallf      = 1'b0;
        #1;
        chk("t5_valid", 32'(validf), 32'd0);
        chk("t5_instr", instrf, NOP);
        chk("t5_addr", imem_addr, 32'h40);
        chk("t5_req2", 32'(imem_req), 32'd1);
        cyc();
        cyc();
        chk("t5_valid2", 32'(validf), 32'd1);
        chk("t5_pcf", pcf, 32'h40);
        chk("t5_instr2", instrf, mem_word(32'h40));

        // T3: 3-cycle memory, redirect one cycle after the request
        lat = 3;
        #1;
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", imem_addr, 32'h44);
        cyc();
        pc_redirect = 1'b1;
        pc_target   = 32'h100;
        #1;
        chk("t3_req_wait", 32'(imem_req), 32'd0);
        cyc();
        pc_redirect = 1'b0;
        #1;
        chk("t3_addr_redir", imem_addr, 32'h100);
        chk("t3_req_killed", 32'(imem_req), 32'd0);
        chk("t3_valid0", 32'(validf), 32'd0);
        cyc();
        chk("t3_valid_late", 32'(validf), 32'd0);
        chk("t3_req_late", 32'(imem_req), 32'd0);
        cyc();
        chk("t3_valid_drop", 32'(validf), 32'd0);
        chk("t3_req_new", 32'(imem_req), 32'd1);
        chk("t3_addr_new", imem_addr, 32'h100);
        cyc();
        cyc();
        cyc();
        chk("t3_valid_pre", 32'(validf), 32'd0);
        cyc();
        chk("t3_valid_cap", 32'(validf), 32'd1);
        chk("t3_pcf", pcf, 32'h100);
        chk("t3_instr", instrf, mem_word(32'h100));

        // T4: redirect coincident with the response
        lat = 1;
        #1;
        chk("t4_addr", imem_addr, 32'h104);
        cyc();
        pc_redirect = 1'b1;
        pc_target   = 32'h200;
        cyc();
        pc_redirect = 1'b0;
        #1;
        chk("t4_valid", 32'(validf), 32'd0);
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr2", imem_addr, 32'h200);
        cyc();
        cyc();
        chk("t4_valid2", 32'(validf), 32'd1);
        chk("t4_pcf", pcf, 32'h200);
        chk("t4_instr", instrf, mem_word(32'h200));

        // T6: async reset mid-S_WAIT, restart, then PC wrap
        #1;
        chk("t6_addr", imem_addr, 32'h204);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(validf), 32'd0);
        chk("t6_instr", instrf, NOP);
        chk("t6_addr_rst", imem_addr, 32'h0);
        chk("t6_req_rst", 32'(imem_req), 32'd0);
        chk("t6_pcf_rst", pcf, 32'h0);
        chk("t6_pc4f_rst", pc4f, 32'h4);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("t6_req_restart", 32'(imem_req), 32'd1);
        chk("t6_addr_restart", imem_addr, 32'h0);
        cyc();
        cyc();
        chk("t6_valid_restart", 32'(validf), 32'd1);
        chk("t6_instr_restart", instrf, 32'h0050_0093);
        pc_redirect = 1'b1;
        pc_target   = 32'hFFFF_FFFC;
        cyc();
        pc_redirect = 1'b0;
        #1;
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("t6_req_top", 32'(imem_req), 32'd1);
        cyc();
        cyc();
        chk("t6_valid_top", 32'(validf), 32'd1);
        chk("t6_pcf_top", pcf, 32'hFFFF_FFFC);
        chk("t6_pc4f_wrap", pc4f, 32'h0);
        chk("t6_instr_top", instrf, mem_word(32'hFFFF_FFFC));
        chk("t6_addr_wrap", imem_addr, 32'h0);
        chk("t6_req_wrap", 32'(imem_req), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
